// File: rtl/regfile_pkg.sv
// Shared defaults and flattened-bus helpers for the register file with busy scoreboard.
package regfile_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_N_READ = 2;

    // Lowest bit of lane idx inside a bus built from equal-width lanes.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: enable gating, write-first bypass and zero-register override.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              reg_busy,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_busy
);

    logic [DATA_W-1:0] data_next;
    logic              busy_next;
    logic [DATA_W-1:0] data_reg;
    logic              busy_reg;

    // wr_en/rsv_en arrive already filtered for the zero register.
    always_comb begin
        data_next = reg_data;
        busy_next = reg_busy;
        if (BYPASS != 0) begin
            if (clr) begin
                data_next = '0;
                busy_next = 1'b0;
            end else begin
                if (wr_en && (wr_addr == rd_addr)) begin
                    data_next = wr_data;
                    busy_next = 1'b0;
                end
                if (rsv_en && (rsv_addr == rd_addr)) begin
                    busy_next = 1'b1;
                end
            end
        end
        if ((ZERO_REG != 0) && (rd_addr == '0)) begin
            data_next = '0;
            busy_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
            busy_reg <= 1'b0;
        end else if (rd_en) begin
            data_reg <= data_next;
            busy_reg <= busy_next;
        end
    end

    assign rd_data = data_reg;
    assign rd_busy = busy_reg;

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with per-register busy scoreboard and N registered read ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int N_READ   = DEF_N_READ,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [N_READ-1:0]        rd_en,
    input  logic [N_READ*ADDR_W-1:0] rd_addr,
    output logic [N_READ*DATA_W-1:0] rd_data,
    output logic [N_READ-1:0]        rd_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0]  busy_reg;
    logic              wr_ok;
    logic              rsv_ok;

    assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
    assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

    // Reserve is applied after the write so a new producer keeps the register busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            busy_reg <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            busy_reg <= '0;
        end else begin
            if (wr_ok) begin
                mem_reg[wr_addr]  <= wr_data;
                busy_reg[wr_addr] <= 1'b0;
            end
            if (rsv_ok) begin
                busy_reg[rsv_addr] <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_READ; gi++) begin : g_port
            logic [ADDR_W-1:0] addr;
            assign addr = rd_addr[slice_lo(gi, ADDR_W) +: ADDR_W];

            regfile_read_port #(
                .DATA_W  (DATA_W),
                .ADDR_W  (ADDR_W),
                .ZERO_REG(ZERO_REG),
                .BYPASS  (BYPASS)
            ) u_port (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr     (clr),
                .wr_en   (wr_ok),
                .wr_addr (wr_addr),
                .wr_data (wr_data),
                .rsv_en  (rsv_ok),
                .rsv_addr(rsv_addr),
                .rd_en   (rd_en[gi]),
                .rd_addr (addr),
                .reg_data(mem_reg[addr]),
                .reg_busy(busy_reg[addr]),
                .rd_data (rd_data[slice_lo(gi, DATA_W) +: DATA_W]),
                .rd_busy (rd_busy[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Drives three register-file variants (write-first, read-first, zero-register) with one stimulus stream.
module tb_regfile_scoreboard;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int NR = 2;
    localparam int NC = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              clr;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;
    logic [NR-1:0]     rd_en;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  dout0, dout1, dout2;
    logic [NR-1:0]     bout0, bout1, bout2;

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .N_READ(NR), .ZERO_REG(0), .BYPASS(1)) dut_wf (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(dout0), .rd_busy(bout0));

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .N_READ(NR), .ZERO_REG(0), .BYPASS(0)) dut_rf (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(dout1), .rd_busy(bout1));

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .N_READ(NR), .ZERO_REG(1), .BYPASS(1)) dut_zr (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(dout2), .rd_busy(bout2));

    // Reference model: architectural registers plus the value each read port is expected to hold.
    logic [DW-1:0] m_mem  [NC][8];
    logic          m_busy [NC][8];
    logic [DW-1:0] e_data [NC][NR];
    logic          e_busy [NC][NR];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            for (int a = 0; a < 8; a++) begin
                m_mem[c][a]  = '0;
                m_busy[c][a] = 1'b0;
            end
            for (int p = 0; p < NR; p++) begin
                e_data[c][p] = '0;
                e_busy[c][p] = 1'b0;
            end
        end
    endtask

    // Config 0: write-first; 1: read-first; 2: write-first with hardwired zero register.
    task automatic model_edge();
        for (int c = 0; c < NC; c++) begin
            logic          z;
            logic          byp;
            logic [DW-1:0] nm [8];
            logic          nb [8];
            logic [AW-1:0] a;
            z   = (c == 2);
            byp = (c != 1);
            for (int k = 0; k < 8; k++) begin
                nm[k] = clr ? '0 : m_mem[c][k];
                nb[k] = clr ? 1'b0 : m_busy[c][k];
            end
            if (!clr) begin
                if (wr_en && !(z && wr_addr == 0)) begin
                    nm[wr_addr] = wr_data;
                    nb[wr_addr] = 1'b0;
                end
                if (rsv_en && !(z && rsv_addr == 0)) nb[rsv_addr] = 1'b1;
            end
            for (int p = 0; p < NR; p++) begin
                if (rd_en[p]) begin
                    a = rd_addr[p*AW +: AW];
                    if (z && a == 0) begin
                        e_data[c][p] = '0;
                        e_busy[c][p] = 1'b0;
                    end else if (byp) begin
                        e_data[c][p] = nm[a];
                        e_busy[c][p] = nb[a];
                    end else begin
                        e_data[c][p] = m_mem[c][a];
                        e_busy[c][p] = m_busy[c][a];
                    end
                end
            end
            for (int k = 0; k < 8; k++) begin
                m_mem[c][k]  = nm[k];
                m_busy[c][k] = nb[k];
            end
        end
    endtask

    task automatic check_all();
        logic [NR*DW-1:0] d;
        logic [NR-1:0]    b;
        for (int c = 0; c < NC; c++) begin
            d = (c == 0) ? dout0 : (c == 1) ? dout1 : dout2;
            b = (c == 0) ? bout0 : (c == 1) ? bout1 : bout2;
            for (int p = 0; p < NR; p++) begin
                chk($sformatf("cfg%0d_p%0d_data", c, p), d[p*DW +: DW], e_data[c][p]);
                chk($sformatf("cfg%0d_p%0d_busy", c, p), {7'd0, b[p]}, {7'd0, e_busy[c][p]});
            end
        end
    endtask

    task automatic idle();
        clr = 1'b0; wr_en = 1'b0; rsv_en = 1'b0; rd_en = '0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        wr_addr = '0; wr_data = '0; rsv_addr = '0; rd_addr = '0;
        idle();
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Write then dual-port read of the same register
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
        tick();
        idle(); set_rd(0, 3'd3); set_rd(1, 3'd3);
        tick();
        chk("wr_rd_p0", dout0[7:0], 8'hA5);
        chk("wr_rd_p1", dout0[15:8], 8'hA5);

        // Same-cycle write and read: write-first vs read-first
        idle(); wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h3C; set_rd(0, 3'd2);
        tick();
        chk("bypass_wf", dout0[7:0], 8'h3C);
        chk("bypass_rf", dout1[7:0], 8'h00);

        // Scoreboard: reserve, reserve+write, write alone
        idle(); rsv_en = 1'b1; rsv_addr = 3'd4;
        tick();
        idle(); set_rd(0, 3'd4);
        tick();
        chk("rsv_busy", {7'd0, bout0[0]}, 8'd1);
        idle(); rsv_en = 1'b1; rsv_addr = 3'd4; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h11;
        tick();
        idle(); set_rd(0, 3'd4);
        tick();
        chk("rsv_wr_busy", {7'd0, bout1[0]}, 8'd1);
        chk("rsv_wr_data", dout1[7:0], 8'h11);
        idle(); wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h22; set_rd(1, 3'd4);
        tick();
        chk("wr_clears_busy", {7'd0, bout0[1]}, 8'd0);

        // Clear beats a simultaneous write and reserve
        for (int a = 1; a < 8; a++) begin
            idle(); wr_en = 1'b1; wr_addr = AW'(a); wr_data = 8'(8'h10 + a);
            rsv_en = 1'b1; rsv_addr = AW'(8 - a);
            tick();
        end
        idle(); clr = 1'b1; wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'hFF;
        rsv_en = 1'b1; rsv_addr = 3'd6; set_rd(0, 3'd6); set_rd(1, 3'd1);
        tick();
        chk("clr_wf_data", dout0[7:0], 8'h00);
        for (int a = 0; a < 8; a++) begin
            idle(); set_rd(0, AW'(a)); set_rd(1, AW'(7 - a));
            tick();
        end

        // Zero register ignores write and reserve
        idle(); wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h77; rsv_en = 1'b1; rsv_addr = 3'd0;
        set_rd(0, 3'd0);
        tick();
        chk("zero_data", dout2[7:0], 8'h00);
        chk("zero_busy", {7'd0, bout2[0]}, 8'd0);
        chk("nonzero_data", dout0[7:0], 8'h77);

        // Read enable low holds outputs while address moves
        idle(); rd_addr = {3'd5, 3'd4};
        tick();
        idle(); rd_addr = {3'd1, 3'd7};
        tick();
        chk("hold_p0", dout0[7:0], 8'h77);

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            clr      = ($urandom_range(0, 24) == 0);
            wr_en    = 1'($urandom);
            wr_addr  = AW'($urandom);
            wr_data  = DW'($urandom);
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = ($urandom_range(0, 1) == 0) ? wr_addr : AW'($urandom);
            rd_en    = NR'($urandom);
            rd_addr  = ($urandom_range(0, 2) == 0) ? {wr_addr, rsv_addr} : (NR*AW)'($urandom);
            tick();
        end

        // Asynchronous reset mid-cycle, no clock edge needed
        idle(); wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h5A; set_rd(0, 3'd5); set_rd(1, 3'd5);
        tick();
        idle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_rd(0, 3'd5);
        tick();
        chk("post_reset_r5", dout0[7:0], 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised CPU register file; successor to the fixed 8x8, 2-read/1-write bank.
- Generalised data width, depth and read-port count; adds reset, synchronous clear, write-to-read bypass and an optional hardwired zero register.
- Adds a per-register busy scoreboard so the decode stage can detect RAW hazards against in-flight producers.
- Sits between decode (reserve, read) and writeback (write).

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers.
- N_READ, 2, number of independent registered read ports (1..4).
- ZERO_REG, 0, 1 = register 0 reads as zero, ignores writes and never goes busy.
- BYPASS, 1, 1 = same-cycle write/reserve visible to a read (write-first); 0 = read-first.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of all registers and busy bits.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rsv_en  in  1  reserve strobe; marks destination busy.
- rsv_addr  in  ADDR_W  register to reserve.
- rd_en  in  N_READ  per-port read enable.
- rd_addr  in  N_READ*ADDR_W  flattened read addresses; port i at [i*ADDR_W +: ADDR_W].
- rd_data  out  N_READ*DATA_W  flattened registered read data.
- rd_busy  out  N_READ  registered busy flag of the addressed register.

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, all busy bits = 0, rd_data = 0, rd_busy = 0. Holds while rst_n low. Release is synchronous to the next clk edge.
- Read latency: 1 cycle. rd_data[i] and rd_busy[i] update at the edge where rd_en[i]=1; they hold their previous value when rd_en[i]=0.
- Write: wr_en=1 updates reg[wr_addr] at the edge and clears busy[wr_addr].
- Reserve: rsv_en=1 sets busy[rsv_addr] at the edge.
- Reserve and write to the same address in the same cycle: busy ends 1 (the new producer wins), data is written.
- Write-port priority: clr > (reserve set, write clear) > hold.
- clr=1: all registers and busy bits go to 0 at the edge; wr_en and rsv_en are ignored that cycle.
- Bypass, BYPASS=1: reads return the post-edge state.
  - Same-address wr_en gives rd_data = wr_data.
  - Same-address rsv_en gives rd_busy = 1.
  - clr gives rd_data = 0, rd_busy = 0.
- Bypass, BYPASS=0: reads return the pre-edge register and busy contents.
- ZERO_REG=1: writes/reserves to address 0 are dropped; reads of address 0 return data 0, busy 0 regardless of BYPASS.
- Ports are independent: any number of ports may read the same address in the same cycle.
- Address arithmetic: no wrap or range check needed; ADDR_W covers DEPTH exactly.

Decomposition:
- Shared package regfile_pkg:
  - default DATA_W/ADDR_W/N_READ constants;
  - the slice helper convention for flattened buses.
- Sub-module regfile_read_port: one registered read port holding the rd_en gating, bypass mux and zero-register override. Instantiated N_READ times via generate.
- Storage and scoreboard stay in the top module.

Test Plan:
- Reset: drive rst_n=0 mid-run after writes -> rd_data=0, rd_busy=0 immediately (no clk edge needed); after release, reading reg 5 returns 0x00.
- Write/read: write 0xA5 to reg 3; next cycle read port 0 and port 1 both at addr 3 -> both rd_data=0xA5 one cycle later.
- Bypass, BYPASS=1: same cycle wr_en reg 2 = 0x3C and rd_addr0=2 -> rd_data0=0x3C next cycle. Rerun with BYPASS=0 -> old value 0x00.
- Scoreboard: rsv reg 4 -> rd_busy=1. Same-cycle rsv reg 4 + wr reg 4 = 0x11 -> busy stays 1, data 0x11. Later wr reg 4 alone -> busy=0.
- Clear priority: preload regs 1..7, assert clr together with wr_en reg 6 = 0xFF and rsv reg 6 -> all reads 0, busy 0.
- Zero register and enable: ZERO_REG=1, write 0x77 and rsv to reg 0 -> read 0 / busy 0. With rd_en=0, rd_data holds its previous value while rd_addr changes.
